// File: rtl/dmem_arb_if.sv
// Bus bundle for dmem_arb: two requester ports (a = pipeline MEM stage, b = loader/debug)
// plus the word-wide data memory side.
interface dmem_arb_if #(
    parameter int Width = 32
);
    // Handshake: a requester raises req_x with we/size/uns/addr/wdata and holds them
    // stable until ack_x pulses for one cycle (err_x/rdata_x are valid with that pulse);
    // req_x may stay high during the ack cycle and must drop the cycle after.
    // Keeping it high longer starts a new access.
    logic             req_a;
    logic             we_a;
    logic [1:0]       size_a;
    logic             uns_a;
    logic [Width-1:0] addr_a;
    logic [Width-1:0] wdata_a;
    logic             ack_a;
    logic             err_a;
    logic [Width-1:0] rdata_a;

    logic             req_b;
    logic             we_b;
    logic [1:0]       size_b;
    logic             uns_b;
    logic [Width-1:0] addr_b;
    logic [Width-1:0] wdata_b;
    logic             ack_b;
    logic             err_b;
    logic [Width-1:0] rdata_b;

    logic [Width-1:0] mem_addr;
    logic             mem_we;
    logic [Width-1:0] mem_wr_data;
    logic [Width-1:0] mem_rd;

    modport slave (
        input  req_a, we_a, size_a, uns_a, addr_a, wdata_a,
        output ack_a, err_a, rdata_a,
        input  req_b, we_b, size_b, uns_b, addr_b, wdata_b,
        output ack_b, err_b, rdata_b,
        output mem_addr, mem_we, mem_wr_data,
        input  mem_rd
    );

    modport master (
        output req_a, we_a, size_a, uns_a, addr_a, wdata_a,
        input  ack_a, err_a, rdata_a,
        output req_b, we_b, size_b, uns_b, addr_b, wdata_b,
        input  ack_b, err_b, rdata_b,
        input  mem_addr, mem_we, mem_wr_data,
        output mem_rd
    );
endinterface

// File: rtl/dmem_arb.sv
// Two-port round-robin data memory arbiter; sub-word stores are read-modify-write.
// Define DMEM_ARB_MISALIGN_CHK_EN to flag misaligned half/word accesses with err_x.
module dmem_arb #(
    parameter int Width = 32
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arb_if.slave     bus,
    output logic [1:0]    o_state
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        MERGE  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_sel_b;
    logic             r_last_b;
    logic             r_we;
    logic [1:0]       r_size;
    logic             r_uns;
    logic [Width-1:0] r_addr;
    logic [Width-1:0] r_wdata;
    logic [Width-1:0] r_merge;
    logic             r_ack_a;
    logic             r_ack_b;
    logic [Width-1:0] r_rdata_a;
    logic [Width-1:0] r_rdata_b;

    logic             w_req_a;
    logic             w_req_b;
    logic             w_grant_b;
    logic             w_is_word;
    logic             w_misalign;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [Width-1:0] w_load_val;
    logic [Width-1:0] w_merged;
    logic             w_mem_we;

    // A port whose ack is showing this cycle is still holding req from the finished access.
    assign w_req_a   = bus.req_a & ~r_ack_a;
    assign w_req_b   = bus.req_b & ~r_ack_b;
    assign w_grant_b = w_req_b & (~w_req_a | ~r_last_b);
    assign w_is_word = r_size[1];

`ifdef DMEM_ARB_MISALIGN_CHK_EN
    logic r_err_a;
    logic r_err_b;
    assign w_misalign = ((r_size == 2'b01) & r_addr[0]) | (w_is_word & (|r_addr[1:0]));
    assign bus.err_a  = r_err_a;
    assign bus.err_b  = r_err_b;
`else
    assign w_misalign = 1'b0;
    assign bus.err_a  = 1'b0;
    assign bus.err_b  = 1'b0;
`endif

    assign w_byte = bus.mem_rd[{r_addr[1:0], 3'b000} +: 8];
    assign w_half = bus.mem_rd[{r_addr[1], 4'b0000} +: 16];

    always_comb begin
        w_load_val = bus.mem_rd;
        if (r_size == 2'b00) begin
            w_load_val = {{(Width-8){~r_uns & w_byte[7]}}, w_byte};
        end else if (r_size == 2'b01) begin
            w_load_val = {{(Width-16){~r_uns & w_half[15]}}, w_half};
        end
    end

    always_comb begin
        w_merged = r_merge;
        if (r_size == 2'b00) begin
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end else begin
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
        end
    end

    // Reset gates the write strobe so an aborted access never reaches memory.
    assign w_mem_we = ~rst & (((r_state == ACCESS) & r_we & w_is_word & ~w_misalign) |
                              (r_state == MERGE));

    assign bus.mem_we      = w_mem_we;
    assign bus.mem_addr    = r_addr;
    assign bus.mem_wr_data = (r_state == MERGE) ? w_merged : r_wdata;
    assign bus.ack_a       = r_ack_a;
    assign bus.ack_b       = r_ack_b;
    assign bus.rdata_a     = r_rdata_a;
    assign bus.rdata_b     = r_rdata_b;
    assign o_state         = r_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_sel_b   <= 1'b0;
            r_last_b  <= 1'b1;
            r_we      <= 1'b0;
            r_size    <= 2'b00;
            r_uns     <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_merge   <= '0;
            r_ack_a   <= 1'b0;
            r_ack_b   <= 1'b0;
            r_rdata_a <= '0;
            r_rdata_b <= '0;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
            r_err_a   <= 1'b0;
            r_err_b   <= 1'b0;
`endif
        end else begin
            r_ack_a <= 1'b0;
            r_ack_b <= 1'b0;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
            r_err_a <= 1'b0;
            r_err_b <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_req_a | w_req_b) begin
                        r_sel_b  <= w_grant_b;
                        r_last_b <= w_grant_b;
                        r_we     <= w_grant_b ? bus.we_b    : bus.we_a;
                        r_size   <= w_grant_b ? bus.size_b  : bus.size_a;
                        r_uns    <= w_grant_b ? bus.uns_b   : bus.uns_a;
                        r_addr   <= w_grant_b ? bus.addr_b  : bus.addr_a;
                        r_wdata  <= w_grant_b ? bus.wdata_b : bus.wdata_a;
                        r_state  <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (w_misalign | ~r_we | w_is_word) begin
                        r_ack_a <= ~r_sel_b;
                        r_ack_b <= r_sel_b;
                        r_state <= IDLE;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
                        r_err_a <= ~r_sel_b & w_misalign;
                        r_err_b <= r_sel_b & w_misalign;
`endif
                        if (~r_we & ~w_misalign) begin
                            if (r_sel_b) r_rdata_b <= w_load_val;
                            else         r_rdata_a <= w_load_val;
                        end
                    end else begin
                        r_merge <= bus.mem_rd;
                        r_state <= MERGE;
                    end
                end
                MERGE: begin
                    r_ack_a <= ~r_sel_b;
                    r_ack_b <= r_sel_b;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arb.sv
// Scoreboard bench for dmem_arb: byte-addressed reference memory, per-port expected
// queues filled at issue time and drained by a monitor on each ack.
module tb_dmem_arb;
    localparam int Width = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] state;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arb_if #(.Width(Width)) bus ();

    dmem_arb #(.Width(Width)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .o_state (state)
    );

    // Word memory behind the arbiter (256 bytes) and the bench's byte-level reference.
    logic [31:0] mem [0:63] = '{default: 32'h0};
    logic [7:0]  ref_bytes [0:255] = '{default: 8'h0};

    assign bus.mem_rd = mem[bus.mem_addr[7:2]];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wr_data;

    // Entry: {is_load, err, load_data}
    logic [33:0] exp_a_q[$];
    logic [33:0] exp_b_q[$];
    int          ack_log[$];
    logic [31:0] hold_a = 32'h0;
    logic [31:0] hold_b = 32'h0;
    int          we_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [33:0] model(input logic we, input logic [1:0] size,
                                          input logic uns, input logic [7:0] addr,
                                          input logic [31:0] wdata);
        int n;
        int base;
        logic [31:0] v;
        logic mis;
        n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        base = int'(addr) - (int'(addr) % n);
        mis = 1'b0;
`ifdef DMEM_ARB_MISALIGN_CHK_EN
        mis = (base != int'(addr));
`endif
        if (mis) return {~we, 1'b1, 32'h0};
        if (we) begin
            for (int i = 0; i < n; i++) ref_bytes[base + i] = wdata[8*i +: 8];
            return {1'b0, 1'b0, 32'h0};
        end
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_bytes[base + i]) << (8 * i));
        if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        return {1'b1, 1'b0, v};
    endfunction

    task automatic do_acc(input bit pb, input logic we, input logic [1:0] size,
                          input logic uns, input logic [7:0] addr, input logic [31:0] wdata,
                          input int exp_lat);
        int cyc;
        bit got;
        if (pb) exp_b_q.push_back(model(we, size, uns, addr, wdata));
        else    exp_a_q.push_back(model(we, size, uns, addr, wdata));
        if (pb) begin
            bus.we_b = we; bus.size_b = size; bus.uns_b = uns;
            bus.addr_b = {24'h0, addr}; bus.wdata_b = wdata; bus.req_b = 1'b1;
        end else begin
            bus.we_a = we; bus.size_a = size; bus.uns_a = uns;
            bus.addr_a = {24'h0, addr}; bus.wdata_a = wdata; bus.req_a = 1'b1;
        end
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            got = pb ? bus.ack_b : bus.ack_a;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout port=%0d actual=no_ack required=ack", pb);
        end else if (exp_lat != 0) begin
            chk(pb ? "latency_b" : "latency_a", cyc, exp_lat);
        end
        @(posedge clk); #1;
        if (pb) bus.req_b = 1'b0;
        else    bus.req_a = 1'b0;
    endtask

    task automatic mon_ack(input bit pb, input logic err, inout logic [31:0] hold);
        logic [33:0] e;
        ack_log.push_back(int'(pb));
        if ((pb ? exp_b_q.size() : exp_a_q.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_ack port=%0d actual=ack required=none", pb);
            return;
        end
        e = pb ? exp_b_q.pop_front() : exp_a_q.pop_front();
        chk(pb ? "err_b" : "err_a", {31'h0, err}, {31'h0, e[32]});
        if (e[33] && !e[32]) hold = e[31:0];
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold_a = 32'h0;
            hold_b = 32'h0;
        end else begin
            if (bus.mem_we) begin
                we_cnt++;
                chk("we_state", {31'h0, (state == 2'd1) || (state == 2'd2)}, 32'h1);
            end
            chk("ack_excl", {31'h0, bus.ack_a & bus.ack_b}, 32'h0);
            if (bus.ack_a) mon_ack(1'b0, bus.err_a, hold_a);
            if (bus.ack_b) mon_ack(1'b1, bus.err_b, hold_b);
            chk("rdata_a_hold", bus.rdata_a, hold_a);
            chk("rdata_b_hold", bus.rdata_b, hold_b);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int n0;
        bus.req_a = 0; bus.we_a = 0; bus.size_a = 0; bus.uns_a = 0; bus.addr_a = 0; bus.wdata_a = 0;
        bus.req_b = 0; bus.we_b = 0; bus.size_b = 0; bus.uns_b = 0; bus.addr_b = 0; bus.wdata_b = 0;

        @(negedge clk);
        chk("rst_ack_a", {31'h0, bus.ack_a}, 32'h0);
        chk("rst_ack_b", {31'h0, bus.ack_b}, 32'h0);
        chk("rst_err_a", {31'h0, bus.err_a}, 32'h0);
        chk("rst_err_b", {31'h0, bus.err_b}, 32'h0);
        chk("rst_rdata_a", bus.rdata_a, 32'h0);
        chk("rst_rdata_b", bus.rdata_b, 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
        chk("rst_state", {30'h0, state}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Word store then word load on port a
        w0 = we_cnt;
        do_acc(1'b0, 1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 2);
        chk("word_store_we_cycles", we_cnt - w0, 1);
        do_acc(1'b0, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 2);
        chk("word_load_rdata", bus.rdata_a, 32'hDEADBEEF);

        // Byte read-modify-write on port b
        do_acc(1'b0, 1'b1, 2'b10, 1'b0, 8'h20, 32'h11223344, 2);
        w0 = we_cnt;
        do_acc(1'b1, 1'b1, 2'b00, 1'b0, 8'h21, 32'h000000AA, 3);
        chk("byte_store_we_cycles", we_cnt - w0, 1);
        chk("byte_merge_word", mem[8], 32'h1122AA44);

        // Load extension
        do_acc(1'b0, 1'b1, 2'b10, 1'b0, 8'h30, 32'h80F07F01, 2);
        do_acc(1'b0, 1'b0, 2'b00, 1'b0, 8'h32, 32'h0, 2);
        chk("lb_signed", bus.rdata_a, 32'hFFFFFFF0);
        do_acc(1'b0, 1'b0, 2'b01, 1'b1, 8'h32, 32'h0, 2);
        chk("lhu", bus.rdata_a, 32'h000080F0);
        do_acc(1'b0, 1'b0, 2'b01, 1'b0, 8'h30, 32'h0, 2);
        chk("lh_signed", bus.rdata_a, 32'h00007F01);

        // Misaligned word store
        w0 = we_cnt;
        do_acc(1'b0, 1'b1, 2'b10, 1'b0, 8'h42, 32'hCAFEF00D, 2);
`ifdef DMEM_ARB_MISALIGN_CHK_EN
        chk("misalign_we_cycles", we_cnt - w0, 0);
        chk("misalign_word", mem[16], 32'h0);
`else
        chk("misalign_we_cycles", we_cnt - w0, 1);
        chk("misalign_word", mem[16], 32'hCAFEF00D);
`endif

        // Reset during MERGE aborts the byte store
        @(posedge clk); #1;
        bus.we_a = 1'b1; bus.size_a = 2'b00; bus.uns_a = 1'b0;
        bus.addr_a = 32'h20; bus.wdata_a = 32'h55; bus.req_a = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("merge_state", {30'h0, state}, 32'h2);
        rst = 1'b1;
        bus.req_a = 1'b0;
        @(negedge clk);
        chk("abort_mem_we", {31'h0, bus.mem_we}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_state", {30'h0, state}, 32'h0);
        chk("abort_ack", {31'h0, bus.ack_a}, 32'h0);
        chk("abort_word", mem[8], 32'h1122AA44);

        // Simultaneous requests after reset alternate a, b, a
        n0 = ack_log.size();
        fork
            begin
                do_acc(1'b0, 1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 0);
                do_acc(1'b0, 1'b1, 2'b10, 1'b0, 8'h48, 32'h0BADF00D, 0);
            end
            do_acc(1'b1, 1'b0, 2'b10, 1'b0, 8'h20, 32'h0, 0);
        join
        chk("rr_count", ack_log.size() - n0, 3);
        if (ack_log.size() >= n0 + 3) begin
            chk("rr_first", ack_log[n0], 0);
            chk("rr_second", ack_log[n0+1], 1);
            chk("rr_third", ack_log[n0+2], 0);
        end

        // Random traffic, each port in its own half of memory
        fork
            for (int k = 0; k < 40; k++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                do_acc(1'b0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)), $urandom, 0);
            end
            for (int k = 0; k < 40; k++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                do_acc(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 8'($urandom_range(128, 255)), $urandom, 0);
            end
        join

        repeat (5) @(posedge clk);
        #1;
        chk("exp_a_drained", exp_a_q.size(), 0);
        chk("exp_b_drained", exp_b_q.size(), 0);
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("mem_word_%0d", i), mem[i],
                {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 SHALL have parameter: Width, 32, data/address width of both ports and the memory side.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have ports, x = a (pipeline MEM stage) and b (loader/debug):
- req_x  input  1  access request.
- we_x  input  1  1 = store, 0 = load.
- size_x  input  2  00 byte, 01 half, 10 word; 11 treated as word.
- uns_x  input  1  load zero-extends when 1, sign-extends when 0.
- addr_x  input  Width  byte address.
- wdata_x  input  Width  store data, right-justified.
- ack_x  output  1  one-cycle completion pulse.
- err_x  output  1  misaligned flag, valid with ack_x.
- rdata_x  output  Width  extended load result.
REQ-005 SHALL have memory-side ports: mem_addr  output  Width  byte address to data memory; mem_we  output  1  write enable; mem_wr_data  output  Width  full write word; mem_rd  input  Width  asynchronous read word at mem_addr.

Function
REQ-006 SHALL implement FSM IDLE, ACCESS, MERGE; memory holds word-wide data with no byte enables, so sub-word stores are read-modify-write.
REQ-007 IDLE: if any req_x high, SHALL grant one port, latch its we/size/uns/addr/wdata, record grant, go to ACCESS; else stay IDLE.
REQ-008 Both req high in IDLE: SHALL grant the port not granted most recently (round-robin); after reset port a wins first.
REQ-009 ACCESS, load: SHALL drive mem_addr = latched addr, register extended lane of mem_rd into rdata_x, pulse ack_x, go to IDLE.
REQ-010 ACCESS, word store: SHALL assert mem_we with mem_wr_data = latched wdata, pulse ack_x, go to IDLE.
REQ-011 ACCESS, byte/half store: SHALL capture mem_rd into a merge register with no write, go to MERGE.
REQ-012 MERGE: SHALL assert mem_we with merge word, target lane replaced by wdata[7:0] (byte lane addr[1:0]) or wdata[15:0] (half lane addr[1]), pulse ack_x, go to IDLE.
REQ-013 Latency from granted req to ack SHALL be 2 cycles for loads and word stores, 3 for sub-word stores; no overlap of accesses.
REQ-014 Requester SHALL hold req and fields stable until ack and drop req the cycle after ack; a still-high req is re-arbitrated as a new access.
REQ-015 mem_we SHALL be high only in ACCESS (word store) or MERGE; mem_addr SHALL equal latched address whenever not IDLE.
REQ-016 rdata_x SHALL hold its value until the next load ack on port x; stores and the other port SHALL not change it.
REQ-017 ack_a and ack_b SHALL never be high in the same cycle.

Reset
REQ-018 rst SHALL force IDLE, ack_x = 0, err_x = 0, rdata_x = 0, latched addr = 0, mem_we = 0, round-robin favouring a.
REQ-019 rst in ACCESS or MERGE SHALL abort: no memory write that cycle, no ack.

Configuration
REQ-020 With DMEM_ARB_MISALIGN_CHK_EN defined, half with addr[0]=1 or word with addr[1:0]!=0 SHALL, in ACCESS, suppress mem_we, leave rdata_x unchanged, pulse ack_x with err_x = 1, go to IDLE.
REQ-021 Without DMEM_ARB_MISALIGN_CHK_EN, err_x SHALL be constant 0; word accesses ignore addr[1:0], halves ignore addr[0].

Verification
REQ-022 Port a word store addr 0x10 data 0xDEADBEEF, then load word 0x10 -> mem_we one cycle, ack_a 2 cycles after each req, rdata_a = 0xDEADBEEF.
REQ-023 Word 0x11223344 at 0x20; port b byte store 0xAA to 0x21 -> read then write cycle, ack_b after 3 cycles, memory word 0x1122AA44.
REQ-024 Word 0x80F0_7F01 at 0x30: signed byte load 0x32 -> 0xFFFFFFF0; unsigned half load 0x32 -> 0x000080F0; signed half load 0x30 -> 0x00007F01.
REQ-025 req_a and req_b high same cycle after reset, held through acks -> grants alternate a, b, a; ack_a and ack_b never coincide.
REQ-026 rst asserted during MERGE of byte store -> no mem_we, no ack, next cycle IDLE, target word unchanged.
REQ-027 With macro, word store to 0x42 -> ack with err = 1, no mem_we; without macro -> write to word index 0x10, err = 0.
